alu_arbiter: RTL and testbench

Shares the single-cycle integer ALU between two requesters, for example the execute stage and the cache address/compare path. It accepts one operation at a time through valid/ready handshakes and picks a winner by round-robin when both ports request. It drives the ALU operand and control inputs from registers and returns the registered result and zero flag to the winning port.

---
 rtl/alu_arb_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 45 ++++
 rtl/alu_arbiter.sv | 172 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: types and constants shared by the ALU arbiter and its grant generator.
package alu_arb_pkg;

  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // One-hot mask that selects port p.
  function automatic logic [NUM_PORTS-1:0] port_mask(input logic p);
    port_mask = p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way grant generator with a last_grant register.
// Round-robin on ties by default; defining ALU_ARB_FIXED_PRIO_EN makes
// port 0 win every tie and leaves last_grant without effect on the grant.
module rr_arb2
  import alu_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic                 i_accept,
  output logic [NUM_PORTS-1:0] o_grant
);

  logic                 r_last_grant;
  logic [NUM_PORTS-1:0] w_grant;

  // Grant decode: a lone requester wins, a tie is settled by policy.
  always_comb begin
    w_grant = '0;
    case (i_req)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
`ifdef ALU_ARB_FIXED_PRIO_EN
      2'b11:   w_grant = 2'b01;
`else
      2'b11:   w_grant = port_mask(~r_last_grant);
`endif
      default: w_grant = 2'b00;
    endcase
  end

  // Remember which port won the most recent accepted request; port 1 after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (i_accept) begin
      r_last_grant <= w_grant[1];
    end else begin
      r_last_grant <= r_last_grant;
    end
  end

  assign o_grant = w_grant;

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one single-cycle ALU between two valid/ready requesters.
// Accepts one operation at a time, drives the ALU from issue registers and
// returns the registered result to the owning port. Tie policy is selected in
// rr_arb2 by the ALU_ARB_FIXED_PRIO_EN macro (round-robin when undefined).
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [CTRL_W-1:0]    r_op;
  logic [DATA_W-1:0]    r_a;
  logic [DATA_W-1:0]    r_b;
  logic                 r_owner;
  logic [DATA_W-1:0]    r_result;
  logic                 r_zero;
  logic [NUM_PORTS-1:0] r_rsp_valid;

  logic [NUM_PORTS-1:0] w_req_valid;
  logic [NUM_PORTS-1:0] w_grant;
  logic                 w_idle;
  logic                 w_accept;
  logic                 w_sel;
  logic                 w_owner_rsp_ready;
  logic [CTRL_W-1:0]    w_sel_op;
  logic [DATA_W-1:0]    w_sel_a;
  logic [DATA_W-1:0]    w_sel_b;

  assign w_req_valid = {req1_valid, req0_valid};
  assign w_idle      = (r_state == IDLE);
  // A grant is only ever issued to a requesting port, so any grant in IDLE is a handshake.
  assign w_accept    = w_idle & (|w_grant);
  assign w_sel       = w_grant[1];

  assign w_sel_op = w_sel ? req1_op : req0_op;
  assign w_sel_a  = w_sel ? req1_a  : req0_a;
  assign w_sel_b  = w_sel ? req1_b  : req0_b;

  assign w_owner_rsp_ready = r_owner ? rsp1_ready : rsp0_ready;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (w_req_valid),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  // Next-state logic: accept, one execute cycle, then hold until the owner takes the result.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = EXEC;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      EXEC: begin
        w_state_nxt = RESP;
      end
      RESP: begin
        if (w_owner_rsp_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RESP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Issue registers: capture the winner's operation and identity on accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_owner <= 1'b0;
    end else if (w_accept) begin
      r_op    <= w_sel_op;
      r_a     <= w_sel_a;
      r_b     <= w_sel_b;
      r_owner <= w_sel;
    end else begin
      r_op    <= r_op;
      r_a     <= r_a;
      r_b     <= r_b;
      r_owner <= r_owner;
    end
  end

  // Response register: latch the ALU output at the end of EXEC, flag only the owner port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_rsp_valid <= '0;
    end else if (r_state == EXEC) begin
      r_result    <= alu_result;
      r_zero      <= alu_zero;
      r_rsp_valid <= port_mask(r_owner);
    end else if ((r_state == RESP) && w_owner_rsp_ready) begin
      r_result    <= r_result;
      r_zero      <= r_zero;
      r_rsp_valid <= '0;
    end else begin
      r_result    <= r_result;
      r_zero      <= r_zero;
      r_rsp_valid <= r_rsp_valid;
    end
  end

  assign req0_ready  = w_idle & w_grant[0];
  assign req1_ready  = w_idle & w_grant[1];

  assign rsp0_valid  = r_rsp_valid[0];
  assign rsp1_valid  = r_rsp_valid[1];
  assign rsp0_result = r_result;
  assign rsp1_result = r_result;
  assign rsp0_zero   = r_zero;
  assign rsp1_zero   = r_zero;

  assign alu_a    = r_a;
  assign alu_b    = r_b;
  assign alu_ctrl = r_op;

  assign busy = ~w_idle;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed stimulus, transaction-level model and per-cycle compare.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_ctrl;
  logic        alu_zero;
  logic        busy;

  int n_checks = 0;
  int n_fails  = 0;

  alu_arbiter #(.DATA_W(32), .CTRL_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_zero(rsp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU attached to the arbiter's ALU ports.
  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_ctrl, alu_a, alu_b);
  assign alu_zero   = (alu_result == 32'd0);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit          m_known = 1'b0;
  bit          m_pend  = 1'b0;
  int          m_age   = 0;   // edges since the accept while an operation is in flight
  int          m_owner = 0;
  int          m_last  = 1;
  logic [2:0]  m_op    = 3'd0;
  logic [31:0] m_a     = 32'd0;
  logic [31:0] m_b     = 32'd0;
  logic [31:0] m_res   = 32'd0;
  int          m_g;

  // Which port the arbiter must grant now (-1 = nobody).
  function automatic int model_grant();
    if (m_pend) return -1;
    if (req0_valid && req1_valid) return FIXED ? 0 : (m_last == 0 ? 1 : 0);
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_known = 1'b1;
      m_pend  = 1'b0;
      m_last  = 1;
      m_op    = 3'd0;
      m_a     = 32'd0;
      m_b     = 32'd0;
    end else if (m_known) begin
      m_g = model_grant();
      if (m_pend) begin
        if (m_age >= 2 && (m_owner == 0 ? rsp0_ready : rsp1_ready)) m_pend = 1'b0;
        else m_age++;
      end else if (m_g >= 0) begin
        m_pend  = 1'b1;
        m_age   = 1;
        m_owner = m_g;
        m_last  = m_g;
        m_op    = (m_g == 0) ? req0_op : req1_op;
        m_a     = (m_g == 0) ? req0_a  : req1_a;
        m_b     = (m_g == 0) ? req0_b  : req1_b;
        m_res   = alu_fn(m_op, m_a, m_b);
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    int  cg;
    bit  v0, v1;
    forever begin
      @(negedge clk);
      #2;
      if (m_known) begin
        cg = model_grant();
        v0 = m_pend && m_age >= 2 && m_owner == 0;
        v1 = m_pend && m_age >= 2 && m_owner == 1;
        chk("m_req0_ready", req0_ready, cg == 0);
        chk("m_req1_ready", req1_ready, cg == 1);
        chk("m_busy", busy, m_pend);
        chk("m_rsp0_valid", rsp0_valid, v0);
        chk("m_rsp1_valid", rsp1_valid, v1);
        chk("m_alu_a", alu_a, m_a);
        chk("m_alu_b", alu_b, m_b);
        chk("m_alu_ctrl", alu_ctrl, m_op);
        if (v0) begin
          chk("m_rsp0_result", rsp0_result, m_res);
          chk("m_rsp0_zero", rsp0_zero, m_res == 32'd0);
        end
        if (v1) begin
          chk("m_rsp1_result", rsp1_result, m_res);
          chk("m_rsp1_zero", rsp1_zero, m_res == 32'd0);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic timeout_fail(input string nm);
    n_checks++;
    n_fails++;
    $display("FAIL %s: got timeout, expected event within budget at %0t", nm, $time);
  endtask

  // Entered at negedge+1; returns at negedge+1 of the cycle where port p is ready.
  task automatic wait_ready(input int p);
    bit ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (p == 0 ? req0_ready : req1_ready) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    if (!ok) timeout_fail("wait_ready");
  endtask

  // Entered at negedge+0; returns at negedge+1 of the cycle where either port is ready.
  task automatic wait_any(output int p);
    bit ok = 1'b0;
    p = -1;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (req0_ready) begin p = 0; ok = 1'b1; break; end
      if (req1_ready) begin p = 1; ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) timeout_fail("wait_any");
  endtask

  // Present a request on port p, hold until accepted, drop valid at the next negedge.
  task automatic send(input int p, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    @(negedge clk);
    if (p == 0) begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    else        begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    #1;
    wait_ready(p);
    @(negedge clk);
    if (p == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  // Entered at negedge+0; waits for the response on port p and checks it against literals.
  task automatic wait_rsp(input int p, input logic [31:0] er, input logic ez, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (p == 0 ? rsp0_valid : rsp1_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) timeout_fail(nm);
    else begin
      chk({nm, "_result"}, p == 0 ? rsp0_result : rsp1_result, er);
      chk({nm, "_zero"}, p == 0 ? rsp0_zero : rsp1_zero, ez);
    end
  endtask

  // Serve any still-valid requests until both ports have been accepted.
  task automatic drain();
    int p;
    for (int k = 0; k < 2 && (req0_valid || req1_valid); k++) begin
      wait_any(p);
      @(negedge clk);
      if (p == 0) req0_valid = 1'b0;
      if (p == 1) req1_valid = 1'b0;
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int p;
    int n0;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = 3'd0; req0_a = 32'd0; req0_b = 32'd0;
    req1_op = 3'd0; req1_a = 32'd0; req1_b = 32'd0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_ctrl", alu_ctrl, 32'd0);
    chk("rst_rsp0_valid", rsp0_valid, 1'b0);

    // ADD 5,7 on port 0 with cycle-exact latency
    @(negedge clk);
    req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 32'd5; req0_b = 32'd7;
    #1;
    chk("add_req0_ready", req0_ready, 1'b1);
    chk("add_req1_ready", req1_ready, 1'b0);
    @(negedge clk); req0_valid = 1'b0; #1;
    chk("add_c1_ctrl", alu_ctrl, 32'd0);
    chk("add_c1_a", alu_a, 32'd5);
    chk("add_c1_b", alu_b, 32'd7);
    chk("add_c1_busy", busy, 1'b1);
    @(negedge clk); #1;
    chk("add_c2_valid", rsp0_valid, 1'b1);
    chk("add_c2_result", rsp0_result, 32'd12);
    chk("add_c2_zero", rsp0_zero, 1'b0);
    chk("add_c2_rsp1", rsp1_valid, 1'b0);
    @(negedge clk); #1;
    chk("add_c3_busy", busy, 1'b0);

    // Simultaneous requests right after reset
    reset_pulse();
    req0_valid = 1'b1; req0_op = ALU_SUB; req0_a = 32'd9;    req0_b = 32'd9;
    req1_valid = 1'b1; req1_op = ALU_OR;  req1_a = 32'hF0; req1_b = 32'h0F;
    #1;
    chk("tie1_ready0", req0_ready, 1'b1);
    chk("tie1_ready1", req1_ready, 1'b0);
    @(negedge clk); req0_valid = 1'b0;
    wait_rsp(0, 32'd0, 1'b1, "tie1_sub");
    wait_ready(1);
    @(negedge clk); req1_valid = 1'b0;
    wait_rsp(1, 32'hFF, 1'b0, "tie1_or");
    // Tie after a port-1 grant goes to port 0
    @(negedge clk);
    req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 32'd1; req0_b = 32'd1;
    req1_valid = 1'b1; req1_op = ALU_ADD; req1_a = 32'd2; req1_b = 32'd2;
    #1;
    chk("tie2_ready0", req0_ready, 1'b1);
    chk("tie2_ready1", req1_ready, 1'b0);
    @(negedge clk);
    req0_op = ALU_AND; req0_a = 32'hC; req0_b = 32'hA;   // new port-0 request, still tied
    wait_any(p);
    chk("tie3_winner", p, FIXED ? 32'd0 : 32'd1);
    @(negedge clk);
    if (p == 0) req0_valid = 1'b0;
    if (p == 1) req1_valid = 1'b0;
    drain();
    repeat (4) @(negedge clk);

    // Response back-pressure on port 0 with port 1 waiting
    rsp0_ready = 1'b0;
    send(0, ALU_ADD, 32'd1, 32'd2);
    req1_valid = 1'b1; req1_op = ALU_OR; req1_a = 32'd4; req1_b = 32'd1;
    wait_rsp(0, 32'd3, 1'b0, "stall_add");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("stall_valid", rsp0_valid, 1'b1);
      chk("stall_result", rsp0_result, 32'd3);
      chk("stall_ready1", req1_ready, 1'b0);
      chk("stall_busy", busy, 1'b1);
    end
    @(negedge clk); rsp0_ready = 1'b1; #1;
    chk("stall_rel_valid", rsp0_valid, 1'b1);
    @(negedge clk); #1;
    chk("stall_idle_busy", busy, 1'b0);
    chk("stall_idle_ready1", req1_ready, 1'b1);
    @(negedge clk); req1_valid = 1'b0;
    wait_rsp(1, 32'd5, 1'b0, "stall_or");

    // Reset during EXEC discards the operation
    send(0, ALU_AND, 32'hFFFF, 32'h00FF);
    rst_n = 1'b0;
    #1;
    chk("rexec_busy", busy, 1'b1);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rexec_busy_after", busy, 1'b0);
    chk("rexec_alu_a", alu_a, 32'd0);
    chk("rexec_alu_b", alu_b, 32'd0);
    chk("rexec_alu_ctrl", alu_ctrl, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rexec_rsp0", rsp0_valid, 1'b0);
      chk("rexec_rsp1", rsp1_valid, 1'b0);
    end

    // SLT and an undefined opcode
    send(1, ALU_SLT, 32'd3, 32'd8);
    wait_rsp(1, 32'd1, 1'b0, "slt");
    send(0, 3'b111, 32'd5, 32'd6);
    wait_rsp(0, 32'd0, 1'b1, "undef");

    // Four back-to-back operations with both ports continuously valid
    @(negedge clk);
    req0_valid = 1'b1; req0_op = ALU_SUB; req0_a = 32'd10; req0_b = 32'd3;
    req1_valid = 1'b1; req1_op = ALU_AND; req1_a = 32'd6;  req1_b = 32'd3;
    n0 = 0;
    for (int k = 0; k < 4; k++) begin
      wait_any(p);
      if (p == 0) n0++;
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("cont_port0_grants", n0, FIXED ? 32'd4 : 32'd2);
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected $finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
